elastic_stage_register: RTL and testbench
=========================================

// Module: elastic_stage_register
// PURPOSE
//  Parametrised pipeline stage register carrying a packed control word plus datapath payload between two stages.
//  Valid/ready handshake on both sides and an optional skid entry, so in_ready is registered and full throughput holds.
//  Flush squashes every held entry to a NOP bubble with all side-effect bits cleared.
//  Adds a saturating stall counter. Used between IF/ID/EX/MEM/WB in place of fixed load/flush registers.
// PARAMETERS
//  WIDTH      128              payload bits (control word + data fields, packed by the instantiating stage)
//  SKID       1                1: two entries (main + skid), registered in_ready; 0: single entry, in_ready combinational
//  BUBBLE     '0 (WIDTH bits)  value driven on out_data whenever out_valid=0 and loaded on flush/reset
//  CNT_W      16               stall counter width
// PORTS
//  clk          in   1        clock, all state updates on posedge
//  rst          in   1        synchronous, active-high reset
//  flush        in   1        squash all held entries this cycle
//  in_valid     in   1        upstream presents in_data
//  in_ready     out  1        this stage accepts in_data this cycle
//  in_data      in   WIDTH    upstream payload
//  out_valid    out  1        out_data holds a live instruction
//  out_ready    in   1        downstream accepts out_data this cycle
//  out_data     out  WIDTH    payload to downstream; equals BUBBLE when out_valid=0
//  occupancy    out  2        number of held entries, 0..1+SKID
//  stall_cnt    out  CNT_W    cycles with out_valid=1 && out_ready=0, saturating
// BEHAVIOUR
//  Transfers:
//   - An input transfer occurs when in_valid && in_ready.
//   - An output transfer occurs when out_valid && out_ready.
//  Reset (rst=1 at posedge):
//   - occupancy=0, out_valid=0, out_data=BUBBLE, in_ready=1, stall_cnt=0.
//   - rst overrides flush and both handshakes.
//  States (SKID=1): EMPTY(occ 0), FULL(occ 1, main valid), SKIDDED(occ 2, main+skid valid).
//   EMPTY:   in xfer -> FULL; main<=in_data.
//   FULL:    in xfer && out xfer -> FULL, main<=in_data.
//            in xfer only -> SKIDDED, skid<=in_data.
//            out xfer only -> EMPTY.
//   SKIDDED: out xfer -> FULL, main<=skid. No input transfer is possible (in_ready=0).
//  in_ready:
//   - SKID=1: registered; in_ready = (next occ < 2). Never combinationally depends on out_ready.
//   - SKID=0: in_ready = !out_valid || out_ready.
//  Latency and ordering:
//   - One cycle from an input transfer to out_valid.
//   - Order preserved: main always drains before skid.
//  flush=1 at posedge:
//   - all entries invalidated, occ=0, main/skid<=BUBBLE.
//   - An input transfer presented in the same cycle is dropped, even if in_ready=1.
//   - A simultaneous output transfer is still taken by downstream; flush only defines this block's next state.
//   - stall_cnt is preserved.
//  stall_cnt:
//   - +1 on each cycle where out_valid && !out_ready.
//   - Saturates at 2^CNT_W-1, no wrap.
//   - Cleared only by rst.
//  Output and X rules:
//   - out_data = main when occ>0, else BUBBLE.
//   - No X may propagate from in_data when in_valid=0: data is captured only on an input transfer.
//  occupancy and reset mid-operation:
//   - occupancy is registered and consistent with out_valid (out_valid = occ!=0).
//   - Reset mid-operation discards all entries, identical to reset from idle.
// STRUCTURE
//  Shared package (rv32i_types):
//   - CTRL_NOP constant (branch/mem_read/mem_write/regfile_write=0, pcmux pc_plus4, alu_add), used to build BUBBLE.
//   - stage_occ_t enum {EMPTY, FULL, SKIDDED}.
//  Sub-module: sat_counter #(CNT_W) for stall_cnt (inc, clr, saturating).
//  Storage: main and skid registers; skid is generated only if SKID=1.
// TESTING
//  1 Reset: rst=1 for 2 cycles with in_valid=1, in_data=0xAA -> occ=0, out_valid=0, out_data=BUBBLE, in_ready=1, stall_cnt=0.
//  2 Streaming: out_ready=1, 8 back-to-back inputs 1..8 -> outputs 1..8 one cycle later, in order; in_ready stays 1; occ stays 1.
//  3 Backpressure: SKID=1, out_ready=0, send 0x11,0x22,0x33 -> accept 0x11,0x22; in_ready=0 on the 3rd; occ=2.
//     Then release out_ready -> outputs 0x11,0x22,0x33 in order; stall_cnt increments once per stalled cycle.
//  4 Flush with simultaneous input: occ=2, flush=1 with in_valid=1, in_data=0x44 -> next cycle occ=0, out_data=BUBBLE;
//     0x44 never appears at the output.
//  5 Saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15; rst -> 0.
//  6 SKID=0: out_ready toggled 1,0,1 with a continuous input stream -> in_ready tracks !out_valid||out_ready in the same cycle;
//     no data lost or duplicated (scoreboard).

Source files
------------

// File: rtl/elastic_stage_register_pkg.sv
// Shared RV32I pipeline types: control word layout, the NOP control word used to
// build pipeline bubbles, and the occupancy encoding of an elastic stage.
package rv32i_types;

  typedef enum logic [1:0] {
    PCMUX_PC_PLUS4 = 2'b00,
    PCMUX_ALU_OUT  = 2'b01,
    PCMUX_ALU_MOD2 = 2'b10
  } pcmux_sel_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SLL = 3'b001,
    ALU_SRA = 3'b010,
    ALU_SUB = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SRL = 3'b101,
    ALU_OR  = 3'b110,
    ALU_AND = 3'b111
  } alu_ops_t;

  typedef struct packed {
    pcmux_sel_t pcmux_sel;
    alu_ops_t   aluop;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       regfile_write;
  } ctrl_word_t;

  localparam int CTRL_W = $bits(ctrl_word_t);

  // Encodes to all zeros, so a zero-extended NOP doubles as an all-zero bubble.
  localparam ctrl_word_t CTRL_NOP = '{
    pcmux_sel:     PCMUX_PC_PLUS4,
    aluop:         ALU_ADD,
    branch:        1'b0,
    mem_read:      1'b0,
    mem_write:     1'b0,
    regfile_write: 1'b0
  };

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    SKIDDED = 2'd2
  } stage_occ_t;

  function automatic logic [1:0] occ_count(stage_occ_t s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/elastic_stage_register_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/elastic_stage_register.sv
// Elastic pipeline stage: valid/ready on both sides, optional skid entry for a
// registered in_ready, flush-to-bubble and a saturating stall counter.
module elastic_stage_register
  import rv32i_types::*;
#(
  parameter int               WIDTH  = 128,
  parameter int               SKID   = 1,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(CTRL_NOP),
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_occ_t       state_q, state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_data;
  logic             in_xfer, out_xfer;
  logic             load_main_in, load_main_skid, load_skid;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_valid ? main_q : BUBBLE;
  assign occupancy = occ_count(state_q);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d      = FULL;
          load_main_in = 1'b1;
        end
      end
      FULL: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer && (SKID != 0)) begin
          state_d   = SKIDDED;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      SKIDDED: begin
        if (out_xfer) begin
          state_d        = FULL;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A flush drops any same-cycle input; downstream still takes its transfer.
    if (flush) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: payload storage is reset to the bubble so a squashed entry never holds
  // stale side-effect bits; in_data is captured only on an accepted transfer.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_q <= BUBBLE;
    end else if (load_main_in) begin
      main_q <= in_data;
    end else if (load_main_skid) begin
      main_q <= skid_data;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [WIDTH-1:0] skid_q;
      logic             in_ready_q;

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          skid_q <= BUBBLE;
        end else if (load_skid) begin
          skid_q <= in_data;
        end
      end

      // Registered ready: look ahead at next occupancy, never at out_ready.
      always_ff @(posedge clk) begin
        if (rst) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != SKIDDED);
        end
      end

      assign skid_data = skid_q;
      assign in_ready  = in_ready_q;
    end else begin : g_noskid
      assign skid_data = BUBBLE;
      assign in_ready  = !out_valid || out_ready;
    end
  endgenerate

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .clr(1'b0),
    .inc(out_valid && !out_ready),
    .cnt(stall_cnt)
  );

  a_no_accept_when_skidded: assert property (
    @(posedge clk) disable iff (rst) (state_q == SKIDDED) |-> !in_ready
  );

  a_single_entry_without_skid: assert property (
    @(posedge clk) disable iff (rst) (SKID == 0) |-> (state_q != SKIDDED)
  );

endmodule

// File: tb/tb_elastic_stage_register.sv
// Directed bench for elastic_stage_register: skid, saturating-counter and
// single-entry variants driven from shared inputs.
module tb_elastic_stage_register;

  localparam logic [127:0] NB_BUBBLE = 128'hB0B;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [127:0] in_data;

  logic         a_in_ready, a_out_valid;
  logic [127:0] a_out_data;
  logic [1:0]   a_occ;
  logic [15:0]  a_stall;

  logic         s_in_ready, s_out_valid;
  logic [127:0] s_out_data;
  logic [1:0]   s_occ;
  logic [3:0]   s_stall;

  logic         n_in_ready, n_out_valid;
  logic [127:0] n_out_data;
  logic [1:0]   n_occ;
  logic [15:0]  n_stall;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  elastic_stage_register u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .stall_cnt(a_stall)
  );

  elastic_stage_register #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occupancy(s_occ), .stall_cnt(s_stall)
  );

  elastic_stage_register #(.SKID(0), .BUBBLE(NB_BUBBLE)) u_noskid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
    .occupancy(n_occ), .stall_cnt(n_stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 128'hAA; out_ready = 1'b0;
    tick();
    tick();
    vecs++; if (a_occ !== 2'd0) begin errs++; $display("FAIL reset_occ: got %0d want 0", a_occ); end
    vecs++; if (a_out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    vecs++; if (a_out_data !== 128'h0) begin errs++; $display("FAIL reset_out_data: got %0h want 0", a_out_data); end
    vecs++; if (a_in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    vecs++; if (a_stall !== 16'd0) begin errs++; $display("FAIL reset_stall: got %0d want 0", a_stall); end
    vecs++; if (n_out_data !== NB_BUBBLE) begin errs++; $display("FAIL reset_noskid_bubble: got %0h want %0h", n_out_data, NB_BUBBLE); end
    vecs++; if (n_in_ready !== 1'b1) begin errs++; $display("FAIL reset_noskid_in_ready: got %b want 1", n_in_ready); end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 128'(i);
      #1;
      vecs++; if (a_in_ready !== 1'b1) begin errs++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, a_in_ready); end
      tick();
      vecs++; if (a_out_valid !== 1'b1 || a_out_data !== 128'(i)) begin
        errs++; $display("FAIL stream_out[%0d]: got v=%b d=%0h want v=1 d=%0h", i, a_out_valid, a_out_data, i);
      end
      vecs++; if (a_occ !== 2'd1) begin errs++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, a_occ); end
    end
    in_valid = 1'b0;
    tick();
    vecs++; if (a_occ !== 2'd0) begin errs++; $display("FAIL stream_drain_occ: got %0d want 0", a_occ); end
    vecs++; if (a_stall !== 16'd0) begin errs++; $display("FAIL stream_stall: got %0d want 0", a_stall); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h11;
    #1;
    vecs++; if (a_in_ready !== 1'b1) begin errs++; $display("FAIL bp_ready_1st: got %b want 1", a_in_ready); end
    tick();
    in_data = 128'h22;
    #1;
    vecs++; if (a_in_ready !== 1'b1) begin errs++; $display("FAIL bp_ready_2nd: got %b want 1", a_in_ready); end
    tick();
    vecs++; if (a_occ !== 2'd2) begin errs++; $display("FAIL bp_occ_full: got %0d want 2", a_occ); end
    vecs++; if (a_out_data !== 128'h11) begin errs++; $display("FAIL bp_head: got %0h want 11", a_out_data); end
    vecs++; if (a_in_ready !== 1'b0) begin errs++; $display("FAIL bp_ready_3rd: got %b want 0", a_in_ready); end
    vecs++; if (a_stall !== 16'd1) begin errs++; $display("FAIL bp_stall1: got %0d want 1", a_stall); end
    in_data = 128'h33;
    tick();
    vecs++; if (a_occ !== 2'd2 || a_in_ready !== 1'b0) begin
      errs++; $display("FAIL bp_hold: got occ=%0d rdy=%b want occ=2 rdy=0", a_occ, a_in_ready);
    end
    vecs++; if (a_stall !== 16'd2) begin errs++; $display("FAIL bp_stall2: got %0d want 2", a_stall); end
    out_ready = 1'b1;
    tick();
    vecs++; if (a_out_data !== 128'h22 || a_occ !== 2'd1 || a_in_ready !== 1'b1) begin
      errs++; $display("FAIL bp_drain1: got d=%0h occ=%0d rdy=%b want d=22 occ=1 rdy=1", a_out_data, a_occ, a_in_ready);
    end
    tick();
    vecs++; if (a_out_data !== 128'h33 || a_occ !== 2'd1) begin
      errs++; $display("FAIL bp_drain2: got d=%0h occ=%0d want d=33 occ=1", a_out_data, a_occ);
    end
    in_valid = 1'b0;
    tick();
    vecs++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0) begin
      errs++; $display("FAIL bp_empty: got occ=%0d v=%b want occ=0 v=0", a_occ, a_out_valid);
    end
    vecs++; if (a_stall !== 16'd2) begin errs++; $display("FAIL bp_stall_final: got %0d want 2", a_stall); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h55;
    tick();
    in_data = 128'h66;
    tick();
    vecs++; if (a_occ !== 2'd2) begin errs++; $display("FAIL flush_pre_occ: got %0d want 2", a_occ); end
    flush = 1'b1; in_data = 128'h44;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    vecs++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0) begin
      errs++; $display("FAIL flush_occ: got occ=%0d v=%b want occ=0 v=0", a_occ, a_out_valid);
    end
    vecs++; if (a_out_data !== 128'h0) begin errs++; $display("FAIL flush_bubble: got %0h want 0", a_out_data); end
    vecs++; if (a_stall !== 16'd2) begin errs++; $display("FAIL flush_stall_kept: got %0d want 2", a_stall); end
    vecs++; if (a_in_ready !== 1'b1) begin errs++; $display("FAIL flush_in_ready: got %b want 1", a_in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++; if (a_out_valid !== 1'b0) begin
        errs++; $display("FAIL flush_no_leak[%0d]: got v=%b d=%0h want v=0", i, a_out_valid, a_out_data);
      end
    end
    in_valid = 1'b1; in_data = 128'h99;
    tick();
    in_valid = 1'b0;
    vecs++; if (a_out_data !== 128'h99 || a_occ !== 2'd1) begin
      errs++; $display("FAIL flush_refill: got d=%0h occ=%0d want d=99 occ=1", a_out_data, a_occ);
    end
    tick();
    vecs++; if (a_occ !== 2'd0) begin errs++; $display("FAIL flush_refill_drain: got %0d want 0", a_occ); end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h77;
    tick();
    in_valid = 1'b0;
    repeat (14) tick();
    vecs++; if (s_stall !== 4'd14) begin errs++; $display("FAIL sat_14: got %0d want 14", s_stall); end
    repeat (6) tick();
    vecs++; if (s_stall !== 4'd15) begin errs++; $display("FAIL sat_hold: got %0d want 15", s_stall); end
    vecs++; if (s_out_valid !== 1'b1 || s_out_data !== 128'h77) begin
      errs++; $display("FAIL sat_data: got v=%b d=%0h want v=1 d=77", s_out_valid, s_out_data);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++; if (s_stall !== 4'd0) begin errs++; $display("FAIL sat_reset: got %0d want 0", s_stall); end
  endtask

  task automatic test_noskid();
    logic [0:11]  pat;
    logic [127:0] exp_q[$];
    logic [127:0] next_val;
    logic [127:0] head;
    logic         m_valid, exp_ir, out_x, in_x;
    pat      = 12'b1011_0010_1110;
    next_val = 128'h100;
    m_valid  = 1'b0;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      in_valid  = (c < 12);
      in_data   = next_val;
      out_ready = (c < 12) ? pat[c] : 1'b1;
      #1;
      exp_ir = !m_valid || out_ready;
      vecs++; if (n_in_ready !== exp_ir) begin errs++; $display("FAIL noskid_in_ready[%0d]: got %b want %b", c, n_in_ready, exp_ir); end
      vecs++; if (n_out_valid !== m_valid) begin errs++; $display("FAIL noskid_out_valid[%0d]: got %b want %b", c, n_out_valid, m_valid); end
      if (!m_valid) begin
        vecs++; if (n_out_data !== NB_BUBBLE) begin errs++; $display("FAIL noskid_bubble[%0d]: got %0h want %0h", c, n_out_data, NB_BUBBLE); end
      end
      out_x = m_valid && out_ready;
      in_x  = in_valid && exp_ir;
      if (out_x) begin
        head = exp_q.pop_front();
        vecs++; if (n_out_data !== head) begin errs++; $display("FAIL noskid_order[%0d]: got %0h want %0h", c, n_out_data, head); end
      end
      if (in_x) begin
        exp_q.push_back(in_data);
        next_val = next_val + 128'd1;
      end
      m_valid = in_x ? 1'b1 : (out_x ? 1'b0 : m_valid);
      tick();
    end
    vecs++; if (n_occ !== 2'd0 || n_out_valid !== 1'b0) begin
      errs++; $display("FAIL noskid_final: got occ=%0d v=%b want occ=0 v=0", n_occ, n_out_valid);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_noskid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
